// File: rtl/junction_stack_ctrl_if.sv
// junction_stack_ctrl_if: event inputs and turn-command outputs of the maze sequencer.
interface junction_stack_ctrl_if #(parameter int AW = 4);
    logic          enable;
    logic          junction;
    logic          dead_end;
    logic          goal;
    logic          cmd_ack;
    logic [1:0]    cmd;
    logic          cmd_valid;
    logic [AW:0]   depth;
    logic          backtracking;
    logic          done;
    logic          error;
    logic          overflow;

    modport master (
        output enable, junction, dead_end, goal, cmd_ack,
        input  cmd, cmd_valid, depth, backtracking, done, error, overflow
    );

    modport slave (
        input  enable, junction, dead_end, goal, cmd_ack,
        output cmd, cmd_valid, depth, backtracking, done, error, overflow
    );
endinterface

// File: rtl/junction_stack_ctrl.sv
// junction_stack_ctrl: depth-first maze sequencer keeping a LIFO of the branch tried at each junction.
module junction_stack_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    junction_stack_ctrl_if.slave    bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RUN      = 3'd1;
    localparam logic [2:0] WAIT_ACK = 3'd2;
    localparam logic [2:0] DONE     = 3'd3;
    localparam logic [2:0] ERROR    = 3'd4;

    localparam logic [1:0] CMD_S = 2'd0;
    localparam logic [1:0] CMD_L = 2'd1;
    localparam logic [1:0] CMD_R = 2'd2;
    localparam logic [1:0] CMD_U = 2'd3;

    logic [2:0]    state;
    logic [1:0]    stack [DEPTH];
    logic [AW:0]   depth_r;
    logic [1:0]    cmd_r;
    logic          valid_r, bt_r, done_r, error_r, ovf_r;
    logic [AW-1:0] top_idx;
    logic [1:0]    top;
    logic          full, empty, jct;
    logic          st_we;
    logic [AW-1:0] st_idx;
    logic [1:0]    st_val;

    // depth is 1..DEPTH whenever the top is read, so the low bits minus one wrap to the right slot
    assign top_idx = depth_r[AW-1:0] - 1'b1;
    assign top     = stack[top_idx];
    assign full    = depth_r == (AW+1)'(DEPTH);
    assign empty   = depth_r == '0;
    assign jct     = bus.enable && state == RUN && !bus.goal && bus.junction;

    always_comb begin
        st_we  = jct && (bt_r ? (!empty && top != 2'd2) : !full);
        st_idx = bt_r ? top_idx : depth_r[AW-1:0];
        st_val = !bt_r ? 2'd0 : top == 2'd0 ? 2'd1 : 2'd2;
    end

    always_ff @(posedge clk)
        if (st_we) stack[st_idx] <= st_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || !bus.enable) begin
            state   <= IDLE;
            depth_r <= '0;
            cmd_r   <= CMD_S;
            valid_r <= 1'b0;
            bt_r    <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= RUN;
                    bt_r  <= 1'b0;
                end
                RUN: begin
                    if (bus.goal) begin
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else if (bus.junction && !bt_r) begin
                        if (full) begin
                            error_r <= 1'b1;
                            ovf_r   <= 1'b1;
                            valid_r <= 1'b0;
                            state   <= ERROR;
                        end else begin
                            depth_r <= depth_r + 1'b1;
                            cmd_r   <= CMD_S;
                            valid_r <= 1'b1;
                            state   <= WAIT_ACK;
                        end
                    end else if (bus.junction) begin
                        if (empty) begin
                            error_r <= 1'b1;
                            state   <= ERROR;
                        end else begin
                            cmd_r   <= top == 2'd0 ? CMD_R : top == 2'd1 ? CMD_S : CMD_L;
                            valid_r <= 1'b1;
                            state   <= WAIT_ACK;
                            if (top == 2'd0 || top == 2'd1) bt_r <= 1'b0;
                            else depth_r <= depth_r - 1'b1;
                        end
                    end else if (bus.dead_end) begin
                        cmd_r   <= CMD_U;
                        valid_r <= 1'b1;
                        bt_r    <= !bt_r;
                        state   <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus.goal) begin
                        valid_r <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= DONE;
                    end else if (bus.cmd_ack) begin
                        valid_r <= 1'b0;
                        state   <= RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd          = cmd_r;
    assign bus.cmd_valid    = valid_r;
    assign bus.depth        = depth_r;
    assign bus.backtracking = bt_r;
    assign bus.done         = done_r;
    assign bus.error        = error_r;
    assign bus.overflow     = ovf_r;
endmodule

// File: tb/tb_junction_stack_ctrl.sv
// tb_junction_stack_ctrl: scoreboard bench driving directed and random events against a queue-based maze model.
module tb_junction_stack_ctrl;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int K_CMD = 0, K_DONE = 1, K_ERR = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_DONE = 3, M_ERR = 4;

    typedef struct {
        int kind;
        int cmd;
        int dep;
        int bt;
        int ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    junction_stack_ctrl_if #(.AW(AW)) bus();
    junction_stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mode = M_IDLE;
    int   stk[$];
    int   mbt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input int kind, input int cmd, input int bt, input int ovf);
        exp_t e;
        e.kind = kind;
        e.cmd  = cmd;
        e.dep  = stk.size();
        e.bt   = bt;
        e.ovf  = ovf;
        q.push_back(e);
    endtask

    // Reference model: stack as a queue, one call per clock edge with the inputs that edge will see.
    task automatic model_step(input bit en, input bit j, input bit d, input bit g, input bit a);
        int e;
        if (!en) begin
            mode = M_IDLE;
            stk.delete();
            mbt = 0;
            return;
        end
        case (mode)
            M_IDLE: begin
                mode = M_RUN;
                mbt  = 0;
            end
            M_RUN: begin
                if (g) begin
                    mode = M_DONE;
                    expect_out(K_DONE, 0, mbt, 0);
                end else if (j && mbt == 0) begin
                    if (stk.size() == DEPTH) begin
                        mode = M_ERR;
                        expect_out(K_ERR, 0, mbt, 1);
                    end else begin
                        stk.push_back(0);
                        mode = M_WAIT;
                        expect_out(K_CMD, 0, 0, 0);
                    end
                end else if (j) begin
                    if (stk.size() == 0) begin
                        mode = M_ERR;
                        expect_out(K_ERR, 0, mbt, 0);
                    end else begin
                        e = stk[$];
                        mode = M_WAIT;
                        if (e == 0) begin
                            stk[$] = 1;
                            mbt = 0;
                            expect_out(K_CMD, 2, 0, 0);
                        end else if (e == 1) begin
                            stk[$] = 2;
                            mbt = 0;
                            expect_out(K_CMD, 0, 0, 0);
                        end else begin
                            void'(stk.pop_back());
                            expect_out(K_CMD, 1, 1, 0);
                        end
                    end
                end else if (d) begin
                    mbt  = (mbt == 0) ? 1 : 0;
                    mode = M_WAIT;
                    expect_out(K_CMD, 3, mbt, 0);
                end
            end
            M_WAIT: begin
                if (g) begin
                    mode = M_DONE;
                    expect_out(K_DONE, 0, mbt, 0);
                end else if (a) mode = M_RUN;
            end
            default: ;
        endcase
    endtask

    task automatic cyc(input bit en, input bit j, input bit d, input bit g, input bit a);
        @(negedge clk);
        bus.enable   = en;
        bus.junction = j;
        bus.dead_end = d;
        bus.goal     = g;
        bus.cmd_ack  = a;
        model_step(en, j, d, g, a);
    endtask

    task automatic got(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            chk("unexpected_output_kind", kind, -1);
            return;
        end
        e = q.pop_front();
        chk("out_kind", kind, e.kind);
        chk("out_depth", int'(bus.depth), e.dep);
        if (kind == K_CMD) begin
            chk("cmd", int'(bus.cmd), e.cmd);
            chk("cmd_backtracking", int'(bus.backtracking), e.bt);
        end else begin
            chk("stop_cmd_valid", int'(bus.cmd_valid), 0);
            if (kind == K_ERR) chk("overflow", int'(bus.overflow), e.ovf);
        end
    endtask

    // Monitor: pops one expectation per newly presented command, done or error.
    initial begin
        logic pv, pd, pe;
        pv = 0; pd = 0; pe = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (bus.cmd_valid && !pv) got(K_CMD);
                if (bus.done && !pd) got(K_DONE);
                if (bus.error && !pe) got(K_ERR);
            end
            pv = bus.cmd_valid;
            pd = bus.done;
            pe = bus.error;
        end
    end

    initial begin
        int pj, pd;
        bit en;
        bus.enable = 0; bus.junction = 0; bus.dead_end = 0; bus.goal = 0; bus.cmd_ack = 0;
        repeat (2) @(negedge clk);
        chk("rst_cmd", int'(bus.cmd), 0);
        chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
        chk("rst_depth", int'(bus.depth), 0);
        chk("rst_backtracking", int'(bus.backtracking), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_error", int'(bus.error), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        rst = 0;
        // basic push, then overflow after sixteen junctions
        cyc(1,0,0,0,0); cyc(1,1,0,0,0); cyc(1,0,0,0,1);
        cyc(0,0,0,0,0); cyc(1,0,0,0,0);
        for (int i = 0; i < 17; i++) begin cyc(1,1,0,0,0); cyc(1,0,0,0,1); end
        cyc(0,0,0,0,0);
        @(negedge clk);
        chk("clear_depth", int'(bus.depth), 0);
        chk("clear_error", int'(bus.error), 0);
        chk("clear_overflow", int'(bus.overflow), 0);
        // dropped junction in WAIT_ACK, then junction+goal together
        cyc(1,0,0,0,0); cyc(1,1,0,0,0); cyc(1,1,0,0,0); cyc(1,0,0,0,1); cyc(1,1,0,1,0);
        cyc(0,0,0,0,0);
        // backtracking: RIGHT, STRAIGHT, LEFT pop, RIGHT
        cyc(1,0,0,0,0);
        cyc(1,1,0,0,0); cyc(1,0,0,0,1); cyc(1,1,0,0,0); cyc(1,0,0,0,1);
        for (int i = 0; i < 3; i++) begin
            cyc(1,0,1,0,0); cyc(1,0,0,0,1); cyc(1,1,0,0,0); cyc(1,0,0,0,1);
        end
        cyc(1,1,0,0,0); cyc(1,0,0,0,1);
        cyc(0,0,0,0,0);
        // exhausted maze: backtrack junction with empty stack
        cyc(1,0,0,0,0); cyc(1,0,1,0,0); cyc(1,0,0,0,1); cyc(1,1,0,0,0); cyc(1,0,0,0,0);
        cyc(0,0,0,0,0);
        for (int p = 0; p < 3; p++) begin
            pj = (p == 1) ? 70 : (p == 2) ? 20 : 40;
            pd = (p == 1) ? 5 : (p == 2) ? 50 : 25;
            for (int n = 0; n < 1500; n++) begin
                en = (mode == M_DONE || mode == M_ERR) ? ($urandom_range(0, 3) != 0)
                                                       : ($urandom_range(0, 149) != 0);
                cyc(en, $urandom_range(0, 99) < pj, $urandom_range(0, 99) < pd,
                    $urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1);
            end
        end
        // asynchronous reset while a command is outstanding
        cyc(0,0,0,0,0); cyc(1,0,0,0,0); cyc(1,1,0,0,0);
        @(posedge clk);
        #2;
        chk("pre_rst_cmd_valid", int'(bus.cmd_valid), 1);
        rst = 1;
        #1;
        chk("async_rst_cmd_valid", int'(bus.cmd_valid), 0);
        chk("async_rst_depth", int'(bus.depth), 0);
        @(negedge clk);
        mode = M_IDLE; stk.delete(); mbt = 0;
        bus.junction = 0;
        rst = 0;
        cyc(1,0,0,0,0); cyc(1,1,0,0,0); cyc(1,0,0,0,1);
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/junction_stack_ctrl.md
Name: junction_stack_ctrl

Overview:
Maze-exploration sequencer for the line-following car. It consumes junction, dead-end and goal events from the track-decode logic, and keeps a LIFO of the branch tried at each open junction. It issues one turn command per event to the motor layer, with depth-first backtracking. It sits between the tracker-sensor decode and the motor mode mux in the top-level controller.

Parameters:
DEPTH, 16, number of junction entries in the stack
AW, 4, stack pointer width; must satisfy 2^AW = DEPTH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  run request (switch); low forces IDLE and clears stack
junction  in  1  one-cycle pulse: full-width marker (111) detected
dead_end  in  1  one-cycle pulse: line lost (000) detected
goal  in  1  one-cycle pulse: goal marker reached
cmd_ack  in  1  motor layer finished current maneuver
cmd  out  2  0=STRAIGHT, 1=LEFT, 2=RIGHT, 3=UTURN
cmd_valid  out  1  cmd is valid; held until acknowledged
depth  out  AW+1  current stack occupancy, 0..DEPTH
backtracking  out  1  high while in reverse (backtrack) mode
done  out  1  goal reached, sticky until enable low
error  out  1  unrecoverable: overflow or exhausted maze, sticky until enable low
overflow  out  1  error cause: push attempted with depth==DEPTH

Behaviour:
- Reset: state IDLE, depth=0, cmd=0, cmd_valid=0, backtracking=0, done=0, error=0, overflow=0. Stack contents are don't-care.
- Stack entry: 2-bit branch index (0=straight, 1=left, 2=right, relative to original entry heading). Try order is 0, 1, 2.
- States: IDLE, RUN, WAIT_ACK, DONE, ERROR. All outputs are registered.
- IDLE: enable=1 -> RUN next edge, backtracking=0.
- RUN, forward mode (backtracking=0):
  - junction: push 0; cmd=STRAIGHT; cmd_valid=1; -> WAIT_ACK. The push and the command take effect on the same edge (1-cycle latency from the pulse).
  - dead_end: cmd=UTURN; backtracking<=1; -> WAIT_ACK. The stack is unchanged.
- RUN, backtrack mode (backtracking=1), junction: act on the top entry e.
  - e=0: overwrite top with 1; cmd=RIGHT; backtracking<=0.
  - e=1: overwrite top with 2; cmd=STRAIGHT; backtracking<=0.
  - e=2: pop; cmd=LEFT; backtracking stays 1.
  - In all three cases -> WAIT_ACK.
  - If depth==0 on a backtrack junction: error=1 -> ERROR, with no command.
- RUN, backtrack mode, dead_end: cmd=UTURN; backtracking<=0; -> WAIT_ACK.
- Event priority in the same cycle: goal > junction > dead_end. Any goal in RUN -> DONE with done=1 and no command.
- WAIT_ACK:
  - cmd and cmd_valid are held stable.
  - cmd_ack=1 at an edge -> cmd_valid=0 and -> RUN on that edge.
  - junction and dead_end are ignored (dropped) while in WAIT_ACK.
  - goal in WAIT_ACK -> DONE, cmd_valid=0.
- Overflow: a forward junction with depth==DEPTH -> ERROR, overflow=1, error=1, cmd_valid=0. Depth does not change.
- DONE and ERROR hold until enable=0.
- enable=0 in any state -> IDLE on the next edge. This clears depth, cmd_valid, backtracking, done, error and overflow.
- Asynchronous rst mid-maneuver clears everything immediately, cmd_valid included.
- depth saturates at 0..DEPTH. No pointer wrap-around is permitted.

Test Plan:
1. rst, enable=1, junction pulse -> after 1 edge: cmd=0, cmd_valid=1, depth=1. cmd_ack -> cmd_valid=0, state RUN.
2. From depth=1, top=0: dead_end -> cmd=3, backtracking=1. ack, then junction -> cmd=2 (RIGHT), top=1, backtracking=0, depth=1.
3. From top=2, backtracking=1, depth=2: junction -> cmd=1 (LEFT), depth=1, backtracking=1. A second junction with top=0 -> cmd=2, top=1.
4. 16 forward junctions, each acked -> depth=16. A 17th junction -> error=1, overflow=1, cmd_valid=0, depth=16. enable=0 -> all cleared.
5. junction and goal in the same cycle -> done=1, no cmd_valid, depth unchanged. junction pulse during WAIT_ACK -> ignored, depth unchanged.
6. depth=0, backtracking=1, junction -> error=1, overflow=0. rst asserted while cmd_valid=1 -> cmd_valid=0 immediately, without waiting for a clock edge.
